mutex_arb_n: RTL and testbench

- Clocked, parametrised N-way mutual-exclusion arbiter; successor to the 2-input async mutex.
- Grants exclusive ownership of one shared resource to one of N requesters using a 4-phase req/gnt handshake.
- Arbitration is fair round-robin, not random. Break-before-make is guaranteed between owners.
- Sits between async-domain requesters (optional input synchronisers) and a shared bus/resource in the synchronous island.

---
 rtl/mutex_arb_n.sv | 204 ++++++++++++++++++++
 tb/tb_mutex_arb_n.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mutex_arb_n.sv
// ---------------------------------------------------------------------------
// mutex_arb_n
//
// Clocked N-way mutual-exclusion arbiter. One shared resource is handed to
// one of N requesters over a 4-phase req/gnt handshake. Selection among
// simultaneous requesters is round-robin: the scan starts at the channel
// after the previous owner. Every change of owner passes through at least
// one cycle with no grant (the GAP state), so ownership is break-before-make.
//
// Optional feature (compile-time macro MUTEX_HOLD_LIMIT_EN):
//   When defined, an owner that keeps its request up for HOLD_MAX grant
//   cycles has its grant forcibly removed. The revoked channel gets a
//   one-cycle pulse on 'revoked' and is ignored by the arbiter until it has
//   dropped its request. When undefined, a grant is held for as long as the
//   owner requests it and 'revoked' is constant 0.
//
// Parameters:
//   N           number of requesting channels (2..32)
//   SYNC_STAGES flops per request bit ahead of the arbiter (0..3)
//   HOLD_MAX    grant cycles before forced revoke (1..65535, feature only)
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   req      per-channel level request
//   gnt      per-channel grant, one-hot or zero, registered
//   busy     high while any grant bit is high
//   gnt_id   index of the current owner; holds the last owner when idle
//   revoked  one-cycle pulse on the channel whose grant was forced off
// ---------------------------------------------------------------------------
module mutex_arb_n #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 0,
    parameter int HOLD_MAX    = 255,
    localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic [IW-1:0] gnt_id,
    output logic [N-1:0]  revoked
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  req_s;
    logic [N-1:0]  elig;
    logic [N-1:0]  gnt_q;
    logic          busy_q;
    logic [IW-1:0] gnt_id_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW:0]   scan_sum;

    // ------------------------------------------------------------------
    // Request synchroniser
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = req;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][N-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= req;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hold-limit support
    // ------------------------------------------------------------------
`ifdef MUTEX_HOLD_LIMIT_EN
    logic [15:0]  hold_cnt_q;
    logic [N-1:0] mask_q;
    logic [N-1:0] revoked_q;
    logic         hold_hit;

    // A revoked channel stays out of the scan until its request drops.
    assign elig     = req_s & ~mask_q;
    assign hold_hit = (hold_cnt_q == 16'(HOLD_MAX));
    assign revoked  = revoked_q;
`else
    logic [15:0] unused_hold_max;

    assign elig            = req_s;
    assign revoked         = '0;
    assign unused_hold_max = 16'(HOLD_MAX);
`endif

    // ------------------------------------------------------------------
    // Round-robin selection: scan ptr, ptr+1, ... wrapping mod N.
    // Iterating from the far end lets the nearest eligible channel win
    // by overwriting, with no early exit needed.
    // ------------------------------------------------------------------
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            scan_sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (scan_sum >= (IW+1)'(N)) begin
                scan_sum = scan_sum - (IW+1)'(N);
            end
            if (elig[scan_sum[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_sum[IW-1:0];
            end
        end
    end

    // Pointer value after the current owner lets go: the next channel.
    assign ptr_d = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + 1'b1;

    // ------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
`ifdef MUTEX_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
            mask_q     <= '0;
            revoked_q  <= '0;
`endif
        end else begin
`ifdef MUTEX_HOLD_LIMIT_EN
            revoked_q <= '0;
            mask_q    <= mask_q & req_s;
`endif
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt_q    <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                        state_q  <= S_GRANT;
`ifdef MUTEX_HOLD_LIMIT_EN
                        hold_cnt_q <= 16'd1;
`endif
                    end
                end

                S_GRANT: begin
                    // A release always takes precedence over a revoke.
                    if (!req_s[gnt_id_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= S_GAP;
                    end
`ifdef MUTEX_HOLD_LIMIT_EN
                    else if (hold_hit) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr_q     <= ptr_d;
                        state_q   <= S_GAP;
                        revoked_q <= gnt_q;
                        mask_q    <= (mask_q & req_s) | gnt_q;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
`endif
                end

                S_GAP: begin
                    // Dead cycle between owners; never grants from here.
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_mutex_arb_n.sv
// ---------------------------------------------------------------------------
// tb_mutex_arb_n
//
// Drives two arbiter instances (N=4 with no synchroniser, N=3 with two
// synchroniser stages) through directed scenarios and a randomized phase.
// A behavioural owner/queue model predicts every output on every cycle;
// directed scenarios also pin hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mutex_arb_n;

`ifdef MUTEX_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam int HOLD4 = 5;
    localparam int HOLD3 = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = '0;
    logic [3:0] gnt4;
    logic [3:0] rev4;
    logic       busy4;
    logic [1:0] id4;
    logic [2:0] req3 = '0;
    logic [2:0] gnt3;
    logic [2:0] rev3;
    logic       busy3;
    logic [1:0] id3;

    always #5 clk = ~clk;

    mutex_arb_n #(.N(4), .SYNC_STAGES(0), .HOLD_MAX(HOLD4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .gnt(gnt4),
        .busy(busy4), .gnt_id(id4), .revoked(rev4)
    );

    mutex_arb_n #(.N(3), .SYNC_STAGES(2), .HOLD_MAX(HOLD3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .gnt(gnt3),
        .busy(busy3), .gnt_id(id3), .revoked(rev3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the resource, whether we are in the
    // mandatory idle gap, where the round-robin scan starts, and which
    // channels are locked out after a revoke.
    // ------------------------------------------------------------------
    int         m_owner [2];
    bit         m_gap   [2];
    int         m_ptr   [2];
    int         m_last  [2];
    int         m_cnt   [2];
    logic [3:0] m_rev   [2];
    logic [3:0] m_mask  [2];
    logic [3:0] m_hist  [2][4];

    function automatic int n_of(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    function automatic int s_of(input int u);
        return (u == 0) ? 0 : 2;
    endfunction

    function automatic int hold_of(input int u);
        return (u == 0) ? HOLD4 : HOLD3;
    endfunction

    task automatic model_step(input int u, input logic [3:0] r, input logic rr);
        int         n;
        logic [3:0] rs;
        logic [3:0] nm;
        n = n_of(u);
        if (rr) begin
            m_owner[u] = -1;
            m_gap[u]   = 1'b0;
            m_ptr[u]   = 0;
            m_last[u]  = 0;
            m_cnt[u]   = 0;
            m_rev[u]   = '0;
            m_mask[u]  = '0;
            for (int h = 0; h < 4; h++) m_hist[u][h] = '0;
            return;
        end
        rs = (s_of(u) == 0) ? r : m_hist[u][s_of(u) - 1];
        for (int h = 3; h > 0; h--) m_hist[u][h] = m_hist[u][h-1];
        m_hist[u][0] = r;

        m_rev[u] = '0;
        nm = m_mask[u] & rs;
        if (m_owner[u] >= 0) begin
            if (!rs[m_owner[u]]) begin
                m_ptr[u]   = (m_owner[u] + 1) % n;
                m_owner[u] = -1;
                m_gap[u]   = 1'b1;
            end else if (HOLD_EN && m_cnt[u] == hold_of(u)) begin
                m_rev[u][m_owner[u]] = 1'b1;
                nm[m_owner[u]]       = 1'b1;
                m_ptr[u]   = (m_owner[u] + 1) % n;
                m_owner[u] = -1;
                m_gap[u]   = 1'b1;
            end else begin
                m_cnt[u]++;
            end
        end else if (m_gap[u]) begin
            m_gap[u] = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                int k;
                k = (m_ptr[u] + i) % n;
                if (rs[k] && !m_mask[u][k]) begin
                    m_owner[u] = k;
                    m_last[u]  = k;
                    m_cnt[u]   = 1;
                    break;
                end
            end
        end
        m_mask[u] = HOLD_EN ? nm : 4'b0000;
    endtask

    function automatic logic [3:0] exp_gnt(input int u);
        logic [3:0] e;
        e = '0;
        if (m_owner[u] >= 0) e[m_owner[u]] = 1'b1;
        return e;
    endfunction

    always @(posedge clk) begin
        model_step(0, req4, rst);
        model_step(1, {1'b0, req3}, rst);
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model plus structural invariants
    // ------------------------------------------------------------------
    bit         chk_en = 1'b0;
    logic [3:0] prev4 = '0;
    logic [2:0] prev3 = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] e1;
            logic [3:0] r1;
            e1 = exp_gnt(1);
            r1 = m_rev[1];
            check("gnt4",     gnt4,  exp_gnt(0));
            check("busy4",    busy4, m_owner[0] >= 0);
            check("gnt_id4",  id4,   m_last[0]);
            check("revoked4", rev4,  m_rev[0]);
            check("gnt3",     gnt3,  e1[2:0]);
            check("busy3",    busy3, m_owner[1] >= 0);
            check("gnt_id3",  id3,   m_last[1]);
            check("revoked3", rev3,  r1[2:0]);
            check("inv_onehot4", $countones(gnt4) <= 1, 1);
            check("inv_onehot3", $countones(gnt3) <= 1, 1);
            check("inv_busy4", busy4, |gnt4);
            check("inv_busy3", busy3, |gnt3);
            check("inv_id3_range", id3 <= 2'd2, 1);
            check("inv_bbm4", (prev4 != 0) && (gnt4 != 0) && (gnt4 != prev4), 0);
            check("inv_bbm3", (prev3 != 0) && (gnt3 != 0) && (gnt3 != prev3), 0);
            prev4 = gnt4;
            prev3 = gnt3;
        end
    end

    function automatic int idx_of(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Directed scenarios and random phase
    // ------------------------------------------------------------------
    int         hi;
    int         zc;
    int         busy_cnt;
    int         order [$];
    int         gaps  [$];
    logic [3:0] last_nz;
    bit         dn [4];
    int         hc [4];
    logic [3:0] e_gnt [10];
    logic [3:0] e_rev [10];

    initial begin
        rst  = 1'b1;
        req4 = '0;
        req3 = '0;
        step(2);
        chk_en = 1'b1;

        // Reset mid-grant, then first grant after reset goes to channel 0
        rst = 1'b0; req4 = 4'b0100;
        step(1);
        check("A_pre_gnt", gnt4, 4'b0100);
        rst = 1'b1; req4 = 4'b1111;
        step(1);
        check("A_rst_gnt", gnt4, 4'b0000);
        check("A_rst_busy", busy4, 1'b0);
        check("A_rst_id", id4, 2'd0);
        check("A_rst_rev", rev4, 4'b0000);
        step(1);
        rst = 1'b0;
        step(1);
        check("A_first_gnt", gnt4, 4'b0001);
        check("A_first_id", id4, 2'd0);
        req4 = '0;
        step(3);

        // Single channel: 10 request cycles give 10 grant cycles
        // (5 when the hold limit revokes it)
        req4 = 4'b0100; hi = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (i == 0) check("B_rise", gnt4, 4'b0100);
            if (gnt4 == 4'b0100) hi++;
        end
        check("B_gnt_id", id4, 2'd2);
        req4 = '0;
        step(1);
        check("B_high_cycles", hi, HOLD_EN ? 5 : 10);
        check("B_low", gnt4, 4'b0000);
        check("B_id_hold", id4, 2'd2);
        step(2);

        // Contention: all request, each owner releases after 3 grant cycles
        rst = 1'b1; step(1); rst = 1'b0;
        req4 = 4'b1111; zc = 0; last_nz = '0;
        order.delete(); gaps.delete();
        for (int k = 0; k < 4; k++) begin dn[k] = 1'b0; hc[k] = 0; end
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            step(1);
            if (gnt4 == 4'b0000) begin
                zc++;
            end else if (gnt4 != last_nz) begin
                order.push_back(idx_of(gnt4));
                if (last_nz != 0) gaps.push_back(zc);
                zc = 0;
                last_nz = gnt4;
            end
            for (int k = 0; k < 4; k++) begin
                if (dn[k]) begin
                    req4[k] = 1'b1;
                    dn[k] = 1'b0;
                end else if (gnt4[k]) begin
                    hc[k]++;
                    if (hc[k] == 3) begin
                        req4[k] = 1'b0;
                        dn[k] = 1'b1;
                        hc[k] = 0;
                    end
                end
            end
        end
        check("C_grant_count", order.size(), 5);
        for (int i = 0; i < order.size(); i++) check($sformatf("C_order_%0d", i), order[i], i % 4);
        for (int i = 0; i < gaps.size(); i++) check($sformatf("C_gap_%0d", i), gaps[i], 2);
        req4 = '0;
        step(3);

        // N=3 with two synchroniser stages: latency 3 and wrap to channel 0
        req3 = 3'b100;
        step(2);
        check("D_lat_early", gnt3, 3'b000);
        step(1);
        check("D_lat_gnt", gnt3, 3'b100);
        check("D_lat_id", id3, 2'd2);
        req3 = '0;
        step(6);
        req3 = 3'b101;
        step(2);
        check("D_wrap_early", gnt3, 3'b000);
        step(1);
        check("D_wrap_gnt", gnt3, 3'b001);
        check("D_wrap_id", id3, 2'd0);
        req3 = '0;
        step(6);

        // Hold limit: channel 1 held with channel 3 waiting
        if (HOLD_EN) begin
            e_gnt = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8};
            e_rev = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        end else begin
            e_gnt = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
            e_rev = '{default: 4'h0};
        end
        rst = 1'b1; step(1); rst = 1'b0;
        req4 = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("E_gnt_%0d", i), gnt4, e_gnt[i]);
            check($sformatf("E_rev_%0d", i), rev4, e_rev[i]);
        end
        req4 = 4'b0010; busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (gnt4 != 4'b0000) busy_cnt++;
        end
        check("E_masked_cycles", busy_cnt, HOLD_EN ? 0 : 6);
        req4 = '0;
        step(1);
        req4 = 4'b0010;
        step(3);
        check("E_regrant", gnt4, 4'b0010);
        req4 = '0;
        step(3);

        // Release on the very cycle the count reaches the limit
        rst = 1'b1; step(1); rst = 1'b0;
        req4 = 4'b0001;
        step(5);
        check("F_held", gnt4, 4'b0001);
        req4 = '0;
        step(1);
        check("F_rev", rev4, 4'b0000);
        check("F_gnt", gnt4, 4'b0000);
        step(2);

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 5) == 0) req4[k] = ~req4[k];
            for (int k = 0; k < 3; k++) if ($urandom_range(0, 5) == 0) req3[k] = ~req3[k];
            step(1);
        end
        rst = 1'b0; req4 = '0; req3 = '0;
        step(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
